// File: rtl/alu_writeback_stage_if.sv
// Result bus from the ALU into the writeback stage (valid/ready handshake).
//   master : ALU side, drives in_valid and the result payload, observes in_ready
//   slave  : writeback stage, observes the payload, drives in_ready
interface alu_writeback_stage_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned REG_ADDR_W = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_result;
   logic                  in_n;
   logic                  in_v;
   logic                  in_z;
   logic [REG_ADDR_W-1:0] in_rd;

   modport master (
      output in_valid, in_result, in_n, in_v, in_z, in_rd,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_result, in_n, in_v, in_z, in_rd,
      output in_ready
   );
endinterface

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry skid buffer between the ALU and the register-file
// write port, status flags of the last retired entry, sticky saturation bit and
// a head-entry forwarding source.
// Optional feature macro: WB_SAT_COUNT_EN (saturating count of retired V=1 entries;
// without it sat_count is tied to 0).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_if (slave)       ALU result bus: in_valid/in_ready, in_result, in_n/v/z, in_rd
//   wb_ready            write port can accept a write this cycle
//   rf_we/waddr/wdata   register-file write port (head entry, qualified by wb_ready)
//   fwd_valid/rd/data   head entry as bypass candidate
//   flag_n/z/v          flags of the last retired entry
//   sat_sticky          set by any retired V=1, cleared by clr_sticky
//   clr_sticky          clears sat_sticky and sat_count
//   occupancy           entries held (0..2)
//   sat_count           retired V=1 count
module alu_writeback_stage #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned REG_ADDR_W = 4,
   parameter int unsigned SAT_CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_writeback_stage_if.slave  in_if,
   input  logic                  wb_ready,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_rd,
   output logic [DATA_WIDTH-1:0] fwd_data,
   output logic                  flag_n,
   output logic                  flag_z,
   output logic                  flag_v,
   output logic                  sat_sticky,
   input  logic                  clr_sticky,
   output logic [1:0]            occupancy,
   output logic [SAT_CNT_W-1:0]  sat_count
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic                  n;
      logic                  v;
      logic                  z;
      logic [REG_ADDR_W-1:0] rd;
   } entry_t;

   entry_t head_q;
   entry_t skid_q;
   entry_t in_entry;
   logic   head_valid_q;
   logic   skid_valid_q;
   logic   accept;
   logic   retire;
   logic   retire_sat;

   assign in_entry   = '{result: in_if.in_result, n: in_if.in_n, v: in_if.in_v,
                         z: in_if.in_z, rd: in_if.in_rd};
   // in_ready comes straight from the skid register, never from wb_ready
   assign in_if.in_ready = ~skid_valid_q;
   assign accept     = in_if.in_valid & ~skid_valid_q;
   assign retire     = head_valid_q & wb_ready;
   assign retire_sat = retire & head_q.v;

   // Skid buffer; skid is only ever occupied while head is occupied
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q       <= '0;
         skid_q       <= '0;
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (skid_valid_q) begin
         if (retire) begin
            head_q       <= skid_q;
            skid_valid_q <= 1'b0;
         end
      end else if (accept && (!head_valid_q || retire)) begin
         head_q       <= in_entry;
         head_valid_q <= 1'b1;
      end else if (accept) begin
         skid_q       <= in_entry;
         skid_valid_q <= 1'b1;
      end else if (retire) begin
         head_valid_q <= 1'b0;
      end
   end

   // Flags of the last retired entry and sticky saturation (set beats clear)
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_n     <= 1'b0;
         flag_z     <= 1'b0;
         flag_v     <= 1'b0;
         sat_sticky <= 1'b0;
      end else begin
         if (retire) begin
            flag_n <= head_q.n;
            flag_z <= head_q.z;
            flag_v <= head_q.v;
         end
         if (retire_sat) begin
            sat_sticky <= 1'b1;
         end else if (clr_sticky) begin
            sat_sticky <= 1'b0;
         end
      end
   end

`ifdef WB_SAT_COUNT_EN
   localparam logic [SAT_CNT_W-1:0] SAT_MAX = '1;
   logic [SAT_CNT_W-1:0] sat_count_q;

   // Saturating event counter; clear with a simultaneous event lands on 1
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_count_q <= '0;
      end else if (clr_sticky) begin
         sat_count_q <= retire_sat ? SAT_CNT_W'(1) : '0;
      end else if (retire_sat && (sat_count_q != SAT_MAX)) begin
         sat_count_q <= sat_count_q + SAT_CNT_W'(1);
      end
   end

   assign sat_count = sat_count_q;
`else
   assign sat_count = '0;
`endif

   assign rf_we     = retire & (head_q.rd != '0);
   assign rf_waddr  = head_q.rd;
   assign rf_wdata  = head_q.result;
   assign fwd_valid = head_valid_q & (head_q.rd != '0);
   assign fwd_rd    = head_q.rd;
   assign fwd_data  = head_q.result;
   assign occupancy = {1'b0, head_valid_q} + {1'b0, skid_valid_q};

endmodule
